sprite_pop_controller: RTL

Per-frame position and animation controller for one juggling-ball sprite, directly upstream of the 2-image palette sprite renderer. Takes a free-running target position and pop/respawn requests. Drives the renderer's `x_in`, `y_in`, `pop_in` with values that change only at a frame boundary, so a sprite never tears mid-frame. Runs the show → pop → hidden animation sequence.

---
 rtl/sprite_pop_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sprite_pop_controller.sv
// Frame-synchronous position/animation controller for one pop-able sprite (show -> pop -> hidden).
// Optional build macro SPRITE_POP_BLINK_EN: sprite blinks off-screen during POP frames where cnt[2]==1.
module sprite_pop_controller #(
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int POP_FRAMES = 30
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] target_x_in,
  input  logic [9:0]  target_y_in,
  input  logic        pop_trigger_in,
  input  logic        respawn_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        busy_out
);

  typedef enum logic [1:0] {
    ST_SHOW   = 2'd0,
    ST_POP    = 2'd1,
    ST_HIDDEN = 2'd2
  } state_t;

  localparam logic [11:0] X_MAX    = 12'(H_ACTIVE - WIDTH);
  localparam logic [11:0] Y_MAX    = 12'(V_ACTIVE - HEIGHT);
  localparam logic [10:0] X_OFF    = 11'(H_ACTIVE);
  localparam logic [7:0]  CNT_INIT = 8'(POP_FRAMES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_pop_pend;
  logic        r_resp_pend;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_pop;

  logic        w_fs;
  logic [10:0] w_xc;
  logic [9:0]  w_yc;
  logic        w_pop_req;
  logic        w_resp_req;

  assign w_fs = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));

  // Clamp at 12 bits so a large target can never wrap past the limit.
  assign w_xc = ({1'b0, target_x_in} > X_MAX) ? X_MAX[10:0] : target_x_in;
  assign w_yc = ({2'b00, target_y_in} > Y_MAX) ? Y_MAX[9:0] : target_y_in;

  // A pulse landing on the strobe cycle itself is consumed by that strobe.
  assign w_pop_req  = r_pop_pend | pop_trigger_in;
  assign w_resp_req = r_resp_pend | respawn_in;

`ifdef SPRITE_POP_BLINK_EN
  logic [10:0] r_frz_x;
  logic [7:0]  w_cnt_dec;
  assign w_cnt_dec = r_cnt - 8'd1;
`endif

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= ST_SHOW;
      r_cnt       <= 8'd0;
      r_pop_pend  <= 1'b0;
      r_resp_pend <= 1'b0;
      r_x         <= 11'd0;
      r_y         <= 10'd0;
      r_pop       <= 1'b0;
`ifdef SPRITE_POP_BLINK_EN
      r_frz_x     <= 11'd0;
`endif
    end else begin
      if (w_fs) begin
        r_pop_pend  <= 1'b0;
        r_resp_pend <= 1'b0;
      end else begin
        if (pop_trigger_in) r_pop_pend  <= 1'b1;
        if (respawn_in)     r_resp_pend <= 1'b1;
      end

      if (w_fs) begin
        case (r_state)
          ST_SHOW: begin
            r_x   <= w_xc;
            r_y   <= w_yc;
            r_pop <= 1'b0;
            if (w_pop_req) begin
              r_state <= ST_POP;
              r_pop   <= 1'b1;
              r_cnt   <= CNT_INIT;
`ifdef SPRITE_POP_BLINK_EN
              r_frz_x <= w_xc;
              if (CNT_INIT[2]) r_x <= X_OFF;
`endif
            end
          end
          ST_POP: begin
            if (r_cnt == 8'd0) begin
              r_state <= ST_HIDDEN;
              r_x     <= X_OFF;
              r_pop   <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
`ifdef SPRITE_POP_BLINK_EN
              r_x   <= w_cnt_dec[2] ? X_OFF : r_frz_x;
`endif
            end
          end
          ST_HIDDEN: begin
            // Respawn wins over a simultaneous pop; the pop is simply dropped.
            if (w_resp_req) begin
              r_state <= ST_SHOW;
              r_x     <= w_xc;
              r_y     <= w_yc;
              r_pop   <= 1'b0;
            end else begin
              r_x   <= X_OFF;
              r_pop <= 1'b0;
            end
          end
          default: r_state <= ST_SHOW;
        endcase
      end
    end
  end

  assign x_out    = r_x;
  assign y_out    = r_y;
  assign pop_out  = r_pop;
  assign busy_out = (r_state != ST_SHOW);

endmodule
